// File: rtl/lieat_bpu_pkg.sv
// Shared types and helpers for the lieat two-level branch direction predictor.
// Functions take wide operands so any parametrisation can reuse them via a size cast.
package lieat_bpu_pkg;

    typedef enum logic {
        BPU_INIT,
        BPU_READY
    } bpu_state_e;

    function automatic logic [15:0] cnt_next(
        input logic [15:0] cnt,
        input logic        taken,
        input int          cnt_w
    );
        logic [15:0] cnt_max;
        cnt_max = 16'((32'd1 << cnt_w) - 32'd1);
        if (taken) begin
            return (cnt == cnt_max) ? cnt : cnt + 16'd1;
        end
        return (cnt == 16'd0) ? cnt : cnt - 16'd1;
    endfunction

    // Local mode concatenates {index, hist}; gshare folds the history into the index.
    function automatic logic [31:0] pht_addr(
        input logic [31:0] index,
        input logic [31:0] hist,
        input logic        gshare,
        input int          hist_w
    );
        if (gshare) begin
            return index ^ hist;
        end
        return (index << hist_w) | hist;
    endfunction

endpackage

// File: rtl/lieat_bpu_ctr.sv
// CNT_W-bit saturating direction counter: next value after a resolution plus the
// prediction bit (MSB).
module lieat_bpu_ctr
    import lieat_bpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_upd,
    output logic             msb
);

    assign cnt_upd = CNT_W'(cnt_next(16'(cnt), taken, CNT_W));
    assign msb     = cnt[CNT_W-1];

endmodule

// File: rtl/lieat_ifu_bpu2.sv
// Two-level branch direction predictor (local history or gshare) with RAM-mappable
// tables that are initialised by a sweep after reset or flush.
module lieat_ifu_bpu2
    import lieat_bpu_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int HIST_W  = 2,
    parameter int CNT_W   = 2,
    parameter int GSHARE  = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] index,
    input  logic               inst_bxx,
    output logic               bxx_taken,
    output logic [HIST_W-1:0]  pred_hist,
    input  logic               prdt_en,
    input  logic [INDEX_W-1:0] prdt_index,
    input  logic [HIST_W-1:0]  prdt_hist,
    input  logic               prdt_result,
    input  logic               flush_req,
    output logic               ready
);

    localparam int PHT_AW = (GSHARE != 0) ? INDEX_W : INDEX_W + HIST_W;
    localparam int PHT_N  = 1 << PHT_AW;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

    bpu_state_e        state_reg;
    logic [PHT_AW-1:0] ptr_reg;
    logic              ready_reg;

    logic [CNT_W-1:0]  pht_mem [PHT_N];

    logic [HIST_W-1:0] look_hist;
    logic [HIST_W-1:0] upd_hist;
    logic [HIST_W-1:0] hist_next;
    logic [PHT_AW-1:0] look_addr;
    logic [PHT_AW-1:0] upd_addr;
    logic [CNT_W-1:0]  look_cnt;
    logic [CNT_W-1:0]  upd_cnt;
    logic [CNT_W-1:0]  upd_cnt_nxt;
    logic [CNT_W-1:0]  look_cnt_nxt_unused;
    logic              look_msb;
    logic              upd_msb_unused;
    logic              upd_en;

    assign upd_en    = prdt_en & ready_reg;
    assign hist_next = HIST_W'({upd_hist, prdt_result});

    // The update address comes from the history carried with the branch, not the live one.
    assign look_addr = PHT_AW'(pht_addr(32'(index), 32'(look_hist), GSHARE != 0, HIST_W));
    assign upd_addr  = PHT_AW'(pht_addr(32'(prdt_index), 32'(prdt_hist), GSHARE != 0, HIST_W));
    assign look_cnt  = pht_mem[look_addr];
    assign upd_cnt   = pht_mem[upd_addr];

    lieat_bpu_ctr #(.CNT_W(CNT_W)) u_look_ctr (
        .cnt     (look_cnt),
        .taken   (1'b0),
        .cnt_upd (look_cnt_nxt_unused),
        .msb     (look_msb)
    );

    lieat_bpu_ctr #(.CNT_W(CNT_W)) u_upd_ctr (
        .cnt     (upd_cnt),
        .taken   (prdt_result),
        .cnt_upd (upd_cnt_nxt),
        .msb     (upd_msb_unused)
    );

    assign bxx_taken = ready_reg & inst_bxx & look_msb;
    assign pred_hist = look_hist;
    assign ready     = ready_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BPU_INIT;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                BPU_INIT: begin
                    if (flush_req) begin
                        ptr_reg <= '0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                        if (ptr_reg == '1) begin
                            state_reg <= BPU_READY;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (flush_req) begin
                        state_reg <= BPU_INIT;
                        ptr_reg   <= '0;
                        ready_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state_reg == BPU_INIT) begin
            pht_mem[ptr_reg] <= CNT_INIT;
        end else if (upd_en) begin
            pht_mem[upd_addr] <= upd_cnt_nxt;
        end
    end

    generate
        if (GSHARE == 0) begin : g_local
            logic [HIST_W-1:0] bht_mem [1 << INDEX_W];

            assign look_hist = bht_mem[index];
            assign upd_hist  = bht_mem[prdt_index];

            // Each BHT row is cleared once per 2^HIST_W sweep steps; repeats are harmless.
            always_ff @(posedge clock) begin
                if (state_reg == BPU_INIT) begin
                    bht_mem[ptr_reg[PHT_AW-1 -: INDEX_W]] <= '0;
                end else if (upd_en) begin
                    bht_mem[prdt_index] <= hist_next;
                end
            end
        end else begin : g_gshare
            logic [HIST_W-1:0] ghr_reg;

            assign look_hist = ghr_reg;
            assign upd_hist  = ghr_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ghr_reg <= '0;
                end else if (state_reg == BPU_INIT) begin
                    ghr_reg <= '0;
                end else if (upd_en) begin
                    ghr_reg <= hist_next;
                end
            end
        end
    endgenerate

endmodule
